// File: rtl/mfp_table_pkg.sv
// rtl/mfp_table_pkg.sv - shared encodings, entry type and byte-enable decode for the table writer
package mfp_table_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [8:0] REGION_SPRITE  = 9'h1C0;
  localparam logic [8:0] REGION_PALETTE = 9'h1C1;
  localparam logic [8:0] REGION_TILEMAP = 9'h1C2;

  localparam int ADDR_W_MAX = 12;
  localparam int IDX_W_MAX  = 3;

  typedef struct packed {
    logic [IDX_W_MAX-1:0]  idx;
    logic [ADDR_W_MAX-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            be;
  } tbl_entry_t;

  // Sizes above a word collapse to a full-word write.
  function automatic logic [3:0] size_to_be(input logic [2:0] hsize, input logic [1:0] lsb);
    case (hsize)
      HSIZE_BYTE: size_to_be = 4'b0001 << lsb;
      HSIZE_HALF: size_to_be = lsb[1] ? 4'b1100 : 4'b0011;
      default:    size_to_be = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// rtl/mfp_sync_fifo.sv - single-clock FIFO with naturally wrapping pointers
module mfp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mfp_ahb_table_writer.sv
// rtl/mfp_ahb_table_writer.sv - AHB-Lite slave posting CPU writes into N video lookup tables
module mfp_ahb_table_writer
  import mfp_table_pkg::*;
#(
  parameter int         N_TABLES     = 2,
  parameter int         ADDR_W       = 9,
  parameter int         DATA_W       = 32,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [8:0] REGION_MATCH = REGION_SPRITE
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [31:0]         HADDR,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HSIZE,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA,
  input  logic [N_TABLES-1:0] TBL_READY,
  output logic [N_TABLES-1:0] TBL_WR,
  output logic [ADDR_W-1:0]   TBL_ADDR,
  output logic [DATA_W-1:0]   TBL_DI,
  output logic [3:0]          TBL_BE,
  output logic [7:0]          DROP_CNT
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = $bits(tbl_entry_t);

  logic                 pend_v_q, pend_v_d;
  logic [IDX_W_MAX-1:0] pend_idx_q;
  logic [ADDR_W-1:0]    pend_addr_q;
  logic [3:0]           pend_be_q;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic                 accept, data_done, in_range, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [PTR_W:0]       fifo_count;
  tbl_entry_t           push_entry, head;
  logic [N_TABLES-1:0]  tbl_wr;
  logic                 unused_sigs;

  assign accept    = HREADY && HTRANS[1] && HWRITE && (HADDR[28:20] == REGION_MATCH);
  assign HREADYOUT = !(pend_v_q && fifo_full);
  assign data_done = pend_v_q && !fifo_full;
  // Index is decoded over the full field so unpopulated table slots can be dropped.
  assign in_range  = {1'b0, pend_idx_q} < 4'(N_TABLES);
  assign push      = data_done && in_range;
  assign HRESP     = 1'b0;
  assign HRDATA    = '0;
  assign DROP_CNT  = drop_cnt_q;

  always_comb begin
    pend_v_d = pend_v_q;
    if (accept)         pend_v_d = 1'b1;
    else if (data_done) pend_v_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    if (data_done && !in_range && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pend_v_q    <= 1'b0;
      pend_idx_q  <= '0;
      pend_addr_q <= '0;
      pend_be_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      drop_cnt_q <= drop_cnt_d;
      if (accept) begin
        pend_idx_q  <= HADDR[ADDR_W+2 +: IDX_W_MAX];
        pend_addr_q <= HADDR[ADDR_W+1:2];
        pend_be_q   <= size_to_be(HSIZE, HADDR[1:0]);
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.idx  = pend_idx_q;
    push_entry.addr = ADDR_W_MAX'(pend_addr_q);
    push_entry.data = 32'(HWDATA);
    push_entry.be   = pend_be_q;
  end

  mfp_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Only the head is ever offered, so a stalled table blocks all later writes.
  always_comb begin
    tbl_wr = '0;
    for (int t = 0; t < N_TABLES; t++) begin
      tbl_wr[t] = !fifo_empty && (head.idx == IDX_W_MAX'(t)) && TBL_READY[t];
    end
  end

  assign pop      = |tbl_wr;
  assign TBL_WR   = tbl_wr;
  assign TBL_ADDR = fifo_empty ? '0 : head.addr[ADDR_W-1:0];
  assign TBL_DI   = fifo_empty ? '0 : DATA_W'(head.data);
  assign TBL_BE   = fifo_empty ? '0 : head.be;

  assign unused_sigs = ^{HADDR[31:29], HADDR[19:ADDR_W+5], HTRANS[0], fifo_count, head.addr};

endmodule

// File: tb/tb_mfp_ahb_table_writer.sv
// tb/tb_mfp_ahb_table_writer.sv - randomized self-checking bench for mfp_ahb_table_writer
module tb_mfp_ahb_table_writer;

  typedef struct {
    logic        wr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic        CLK, RESETn;
  logic [31:0] HADDR, HWDATA, HRDATA, TBL_DI;
  logic        HWRITE, HREADY, HREADYOUT, HRESP;
  logic [1:0]  HTRANS, TBL_READY, TBL_WR;
  logic [2:0]  HSIZE;
  logic [8:0]  TBL_ADDR;
  logic [3:0]  TBL_BE;
  logic [7:0]  DROP_CNT;

  int    n_checks, n_pass, cyc, onehot_err, drop_exp, stall_cycles, first_stall_dp;
  xfer_t xq[$];
  ent_t  exp_q[$], obs_q[$];
  int    obs_cyc[$];

  assign HREADY = HREADYOUT;

  mfp_ahb_table_writer dut (
    .CLK(CLK), .RESETn(RESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .TBL_READY(TBL_READY), .TBL_WR(TBL_WR),
    .TBL_ADDR(TBL_ADDR), .TBL_DI(TBL_DI), .TBL_BE(TBL_BE), .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    ent_t e;
    if (RESETn && TBL_WR != 0) begin
      if (!$onehot(TBL_WR)) onehot_err++;
      e.idx  = TBL_WR[1] ? 3'd1 : 3'd0;
      e.addr = TBL_ADDR;
      e.data = TBL_DI;
      e.be   = TBL_BE;
      obs_q.push_back(e);
      obs_cyc.push_back(cyc);
    end
  end

  // Reference model: what the tables should eventually receive, in bus order.
  task automatic model_xfer(input xfer_t x);
    ent_t e;
    int   idx;
    if (!(x.wr && x.trans >= 2 && x.addr[28:20] == 9'h1C0)) return;
    idx = int'((x.addr >> 11) & 32'd7);
    if (idx >= 2) begin
      if (drop_exp < 255) drop_exp++;
      return;
    end
    e.idx  = 3'(idx);
    e.addr = 9'((x.addr >> 2) & 32'h1FF);
    e.data = x.data;
    if (x.size == 0)      e.be = 4'(1 << (x.addr % 4));
    else if (x.size == 1) e.be = 4'(3 << (x.addr & 2));
    else                  e.be = 4'd15;
    exp_q.push_back(e);
  endtask

  function automatic xfer_t mk_write(input int idx);
    xfer_t x;
    x.wr    = 1'b1;
    x.trans = 2'($urandom_range(2, 3));
    x.size  = 3'($urandom_range(0, 7));
    x.addr  = {3'($urandom), 9'h1C0, 6'($urandom), 3'(idx), 9'($urandom), 2'($urandom)};
    x.data  = $urandom;
    return x;
  endfunction

  function automatic xfer_t mk_noise();
    xfer_t x;
    x = mk_write(int'($urandom_range(0, 1)));
    case ($urandom_range(0, 3))
      0: x.trans = 2'b00;
      1: x.trans = 2'b01;
      2: x.wr = 1'b0;
      default: x.addr[28:20] = 9'h1C0 ^ 9'($urandom_range(1, 511));
    endcase
    return x;
  endfunction

  task automatic drive_addr(input xfer_t x);
    HADDR = x.addr; HWRITE = x.wr; HTRANS = x.trans; HSIZE = x.size;
  endtask

  task automatic drive_idle();
    HADDR = 0; HWRITE = 0; HTRANS = 2'b00; HSIZE = 0;
  endtask

  // Pipelined AHB master; call just after a rising edge. Every xfer is also fed to the model.
  task automatic run_bus(input int budget);
    int    ai, dp_num, n;
    bit    dp_v, rdy;
    ai = 0; dp_num = 0; n = 0; dp_v = 0;
    stall_cycles = 0; first_stall_dp = 0;
    foreach (xq[i]) model_xfer(xq[i]);
    if (xq.size() > 0) drive_addr(xq[0]); else drive_idle();
    while ((ai < xq.size() || dp_v) && n < budget) begin
      @(negedge CLK);
      rdy = HREADYOUT;
      if (!rdy) begin
        stall_cycles++;
        if (first_stall_dp == 0) first_stall_dp = dp_num;
      end
      @(posedge CLK); #1;
      n++;
      if (rdy) begin
        dp_v = (ai < xq.size());
        if (dp_v) begin
          HWDATA = xq[ai].data;
          ai++;
          dp_num++;
        end
        if (ai < xq.size()) drive_addr(xq[ai]); else drive_idle();
      end
    end
    n_checks++;
    if (n >= budget) $display("FAIL bus_timeout: cycles=%0d budget=%0d", n, budget);
    else n_pass++;
    xq.delete();
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    RESETn = 0; TBL_READY = 2'b11; HWDATA = 0; drive_idle();
    @(negedge CLK);
    n_checks++;
    if ({HREADYOUT, HRESP, HRDATA, TBL_WR, TBL_ADDR, TBL_DI, TBL_BE, DROP_CNT} !==
        {1'b1, 1'b0, 32'd0, 2'd0, 9'd0, 32'd0, 4'd0, 8'd0})
      $display("FAIL reset_values: rdy=%b resp=%b rd=%h wr=%b addr=%h di=%h be=%h drop=%0d",
               HREADYOUT, HRESP, HRDATA, TBL_WR, TBL_ADDR, TBL_DI, TBL_BE, DROP_CNT);
    else n_pass++;
    @(posedge CLK); #1;
    RESETn = 1;
    settle(1);
  endtask

  task automatic test_single();
    xfer_t x;
    clear_sb();
    x.wr = 1; x.trans = 2'b10; x.size = 3'b010; x.data = 32'hDEADBEEF;
    x.addr = {3'b0, 9'h1C0, 6'b0, 3'd1, 9'h005, 2'b00};
    drive_addr(x);
    @(posedge CLK); #1;
    HWDATA = x.data; drive_idle();
    @(negedge CLK);
    n_checks++;
    if (TBL_WR !== 2'b00) $display("FAIL single_a1: TBL_WR=%b want 00", TBL_WR); else n_pass++;
    @(negedge CLK);
    n_checks++;
    if ({TBL_WR, TBL_ADDR, TBL_DI, TBL_BE} !== {2'b10, 9'd5, 32'hDEADBEEF, 4'hF})
      $display("FAIL single_a2: wr=%b addr=%h di=%h be=%h want 10/005/deadbeef/f",
               TBL_WR, TBL_ADDR, TBL_DI, TBL_BE);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (TBL_WR !== 2'b00) $display("FAIL single_a3: TBL_WR=%b want 00", TBL_WR); else n_pass++;
    settle(1);
  endtask

  task automatic test_byte_enables();
    xfer_t x;
    clear_sb();
    x = mk_write(0); x.size = 3'b000; x.addr[1:0] = 2'b10; xq.push_back(x);
    x = mk_write(1); x.size = 3'b001; x.addr[1:0] = 2'b10; xq.push_back(x);
    run_bus(50);
    settle(4);
    n_checks++;
    if (obs_q.size() != 2) $display("FAIL be_count: got=%0d want 2", obs_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (obs_q[0].be !== 4'b0100 || obs_q[1].be !== 4'b1100)
        $display("FAIL be_values: got=%b,%b want 0100,1100", obs_q[0].be, obs_q[1].be);
      else n_pass++;
      n_checks++;
      if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1])
        $display("FAIL be_entries: got=%h,%h want %h,%h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_sb();
    TBL_READY = 2'b00;
    for (int i = 0; i < 6; i++) xq.push_back(mk_write(int'($urandom_range(0, 1))));
    fork
      run_bus(200);
      begin
        repeat (12) @(posedge CLK);
        #1 TBL_READY = 2'b11;
      end
    join
    settle(8);
    n_checks++;
    if (first_stall_dp != 5) $display("FAIL b2b_first_stall: dp=%0d want 5", first_stall_dp);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 6) $display("FAIL b2b_count: got=%0d want 6", obs_q.size());
    else begin
      n_pass++;
      ok = 1;
      for (int i = 0; i < 6; i++) if (obs_q[i] !== exp_q[i]) ok = 0;
      for (int i = 1; i < 6; i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) ok = 0;
      n_checks++;
      if (!ok) $display("FAIL b2b_order: first got=%h want %h, cyc0=%0d cyc5=%0d",
                        obs_q[0], exp_q[0], obs_cyc[0], obs_cyc[5]);
      else n_pass++;
    end
  endtask

  task automatic test_interleave();
    int errs;
    clear_sb();
    TBL_READY = 2'b11;
    for (int i = 0; i < 30; i++)
      xq.push_back((i % 2 == 0) ? mk_write(int'($urandom_range(0, 1))) : mk_noise());
    run_bus(200);
    settle(6);
    n_checks++;
    if (stall_cycles != 0) $display("FAIL interleave_stall: stalls=%0d want 0", stall_cycles);
    else n_pass++;
    errs = (obs_q.size() != exp_q.size()) ? 1 : 0;
    if (errs == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL interleave_sb: got=%0d entries want %0d, errs=%0d",
                            obs_q.size(), exp_q.size(), errs);
    else n_pass++;
  endtask

  task automatic test_drop_saturate();
    clear_sb();
    xq.push_back(mk_write(2));
    run_bus(50);
    settle(3);
    n_checks++;
    if (DROP_CNT !== 8'd1 || obs_q.size() != 0)
      $display("FAIL drop_one: cnt=%0d strobes=%0d want 1/0", DROP_CNT, obs_q.size());
    else n_pass++;
    for (int i = 1; i < 300; i++) xq.push_back(mk_write(int'($urandom_range(2, 7))));
    run_bus(600);
    settle(3);
    n_checks++;
    if (DROP_CNT !== 8'd255 || DROP_CNT != drop_exp[7:0] || obs_q.size() != 0)
      $display("FAIL drop_sat: cnt=%0d model=%0d strobes=%0d want 255", DROP_CNT, drop_exp, obs_q.size());
    else n_pass++;
  endtask

  task automatic test_random_mix();
    bit done;
    int errs;
    clear_sb();
    done = 0;
    for (int i = 0; i < 80; i++)
      xq.push_back(($urandom_range(0, 9) < 6) ? mk_write(int'($urandom_range(0, 3))) : mk_noise());
    fork
      begin
        run_bus(2000);
        done = 1;
      end
      while (!done) begin
        @(posedge CLK); #1;
        TBL_READY = 2'($urandom);
      end
    join
    TBL_READY = 2'b11;
    settle(10);
    errs = (obs_q.size() != exp_q.size()) ? 1 : 0;
    if (errs == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    n_checks++;
    if (errs != 0) $display("FAIL random_sb: got=%0d entries want %0d, errs=%0d",
                            obs_q.size(), exp_q.size(), errs);
    else n_pass++;
    n_checks++;
    if (DROP_CNT != drop_exp[7:0]) $display("FAIL random_drop: cnt=%0d want %0d", DROP_CNT, drop_exp);
    else n_pass++;
    n_checks++;
    if (onehot_err != 0) $display("FAIL onehot: violations=%0d want 0", onehot_err);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [1:0] want_wr;
    clear_sb();
    TBL_READY = 2'b00;
    for (int i = 0; i < 3; i++) xq.push_back(mk_write(int'($urandom_range(0, 1))));
    run_bus(100);
    settle(2);
    want_wr = 2'(1 << exp_q[0].idx);
    TBL_READY = 2'b11;
    #1;
    n_checks++;
    if (TBL_WR !== want_wr) $display("FAIL midflight_strobe: TBL_WR=%b want %b", TBL_WR, want_wr);
    else n_pass++;
    #1 RESETn = 0;
    #1;
    n_checks++;
    if ({TBL_WR, TBL_ADDR, TBL_DI, TBL_BE, DROP_CNT} !== '0)
      $display("FAIL midflight_reset: wr=%b addr=%h di=%h be=%h drop=%0d want all 0",
               TBL_WR, TBL_ADDR, TBL_DI, TBL_BE, DROP_CNT);
    else n_pass++;
    @(posedge CLK); #1;
    RESETn = 1;
    settle(3);
    @(negedge CLK);
    n_checks++;
    if (obs_q.size() != 0 || HREADYOUT !== 1'b1 || TBL_WR !== 2'b00)
      $display("FAIL after_reset: strobes=%0d rdy=%b wr=%b want 0/1/00", obs_q.size(), HREADYOUT, TBL_WR);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; onehot_err = 0; drop_exp = 0;
    test_reset();
    test_single();
    test_byte_enables();
    test_back_to_back();
    test_interleave();
    test_drop_saturate();
    test_random_mix();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
